io_timer: RTL and testbench

- IO-bus responder: an 8-bit programmable down-counter timer on the core's port-mapped IO bus.
- Decodes the core's io_addr/io_data/io_we outputs, returns read data on the core's io_data input, and drives the core's level-sensitive irq input.
- First interrupt source for the EI/DI/HALT path. Registers sit at BASE_ADDR..BASE_ADDR+4.

---
 rtl/io_timer_pkg.sv | 29 ++
 rtl/io_timer_prescaler.sv | 30 +++
 rtl/io_timer.sv | 173 +++++++++++++++++
 tb/tb_io_timer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_timer_pkg.sv
// Shared definitions for io_timer: register offsets, CTRL/STATUS bit positions,
// FSM state type and the prescaler limit helper.
package io_timer_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_RELOAD = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_CAPT   = 3'd4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_PSEL_LO = 4;
    localparam int CTRL_PSEL_HI = 6;

    localparam int STAT_PEND = 0;
    localparam int STAT_OVR  = 1;
    localparam int STAT_RUN  = 2;
    localparam int STAT_CAPF = 3;

    typedef enum logic [1:0] {ST_STOP, ST_LOAD, ST_RUN} io_timer_state_t;

    // Terminal prescaler value for a divide of 2^psel.
    function automatic logic [7:0] presc_limit(input logic [2:0] psel);
        return 8'h7F >> (3'd7 - psel);
    endfunction

endpackage

// File: rtl/io_timer_prescaler.sv
// Prescaler for io_timer: counts while not cleared and emits one tick every 2^psel cycles.
module io_timer_prescaler
    import io_timer_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear,
    input  logic [2:0] psel,
    output logic       tick
);

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] limit;

    assign limit = PRESC_W'(presc_limit(psel));
    assign tick  = ~clear & (presc == limit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc <= '0;
        end else if (clear || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/io_timer.sv
// Port-mapped 8-bit down-counter timer with level interrupt.
// Optional capture input enabled by defining IO_TIMER_CAPTURE_EN.
//
// state   | meaning
// ST_STOP | count holds, prescaler cleared
// ST_LOAD | one cycle: count <= RELOAD, prescaler cleared
// ST_RUN  | prescaler runs, count decrements on each tick
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter int         PRESC_W   = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] io_addr_i,
    input  logic [7:0] io_data_i,
    input  logic       io_we_i,
    output logic [7:0] io_data_o,
    output logic       irq_o
`ifdef IO_TIMER_CAPTURE_EN
    ,
    input  logic       capture_i
`endif
);

    io_timer_state_t state;

    logic       en, auto_rl, irq_en;
    logic [2:0] psel;
    logic [7:0] reload, count;
    logic       pend, ovr;
    logic [7:0] capt;
    logic       capf;

    logic       hit;
    logic [2:0] off;
    logic       wr_ctrl, wr_reload, wr_count, wr_status;
    logic       tick, expire, running;
    logic [7:0] rd_data;

    // BASE_ADDR is 8-aligned, so the low three address bits select the register.
    assign hit       = (io_addr_i[7:3] == BASE_ADDR[7:3]);
    assign off       = io_addr_i[2:0];
    assign wr_ctrl   = io_we_i & hit & (off == OFF_CTRL);
    assign wr_reload = io_we_i & hit & (off == OFF_RELOAD);
    assign wr_count  = io_we_i & hit & (off == OFF_COUNT);
    assign wr_status = io_we_i & hit & (off == OFF_STATUS);

    assign running = (state != ST_STOP);
    assign expire  = tick & (count == 8'h00);

    io_timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  ((state != ST_RUN) | wr_count),
        .psel   (psel),
        .tick   (tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_STOP;
        end else if (wr_ctrl && !io_data_i[CTRL_EN]) begin
            state <= ST_STOP;
        end else begin
            case (state)
                ST_STOP: if (wr_ctrl) state <= ST_LOAD;
                ST_LOAD: state <= ST_RUN;
                ST_RUN:  if (expire && !auto_rl) state <= ST_STOP;
                default: state <= ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            irq_en  <= 1'b0;
            psel    <= 3'd0;
        end else if (wr_ctrl) begin
            en      <= io_data_i[CTRL_EN];
            auto_rl <= io_data_i[CTRL_AUTO];
            irq_en  <= io_data_i[CTRL_IRQ_EN];
            psel    <= io_data_i[CTRL_PSEL_HI:CTRL_PSEL_LO];
        end else if (expire && !auto_rl) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reload <= 8'h00;
        end else if (wr_reload) begin
            reload <= io_data_i;
        end
    end

    // A COUNT write suppresses the tick, so it always wins over a decrement.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= 8'h00;
        end else if (wr_count) begin
            count <= io_data_i;
        end else if (state == ST_LOAD) begin
            count <= reload;
        end else if (tick) begin
            if (count != 8'h00) begin
                count <= count - 8'd1;
            end else if (auto_rl) begin
                count <= reload;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend  <= 1'b0;
            ovr   <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            pend  <= (pend & ~(wr_status & io_data_i[STAT_PEND])) | expire;
            ovr   <= (ovr & ~(wr_status & io_data_i[STAT_OVR])) | (expire & pend);
            irq_o <= pend & irq_en;
        end
    end

`ifdef IO_TIMER_CAPTURE_EN
    logic [2:0] cap_sync;
    logic       cap_rise;

    assign cap_rise = cap_sync[1] & ~cap_sync[2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_sync <= 3'b000;
            capt     <= 8'h00;
            capf     <= 1'b0;
        end else begin
            cap_sync <= {cap_sync[1:0], capture_i};
            if (cap_rise) capt <= count;
            capf <= (capf & ~(wr_status & io_data_i[STAT_CAPF])) | cap_rise;
        end
    end
`else
    assign capt = 8'h00;
    assign capf = 1'b0;
`endif

    always_comb begin
        rd_data = 8'h00;
        if (hit) begin
            case (off)
                OFF_CTRL:   rd_data = {1'b0, psel, 1'b0, irq_en, auto_rl, en};
                OFF_RELOAD: rd_data = reload;
                OFF_COUNT:  rd_data = count;
                OFF_STATUS: rd_data = {4'b0000, capf, running, ovr, pend};
                OFF_CAPT:   rd_data = capt;
                default:    rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            io_data_o <= 8'h00;
        end else begin
            io_data_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_io_timer.sv
// Scoreboard bench for io_timer: reads push expectations from an arithmetic timeline model,
// a monitor pops and compares them one cycle later. Covers IO_TIMER_CAPTURE_EN when defined.
module tb_io_timer;

    localparam logic [7:0] BASE = 8'h10;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] io_addr_i = 8'h00;
    logic [7:0] io_data_i = 8'h00;
    logic       io_we_i = 1'b0;
    logic [7:0] io_data_o;
    logic       irq_o;
`ifdef IO_TIMER_CAPTURE_EN
    logic       capture_i = 1'b0;
`endif

    io_timer #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .io_addr_i (io_addr_i),
        .io_data_i (io_data_i),
        .io_we_i   (io_we_i),
        .io_data_o (io_data_o),
        .irq_o     (irq_o)
`ifdef IO_TIMER_CAPTURE_EN
        ,
        .capture_i (capture_i)
`endif
    );

    typedef struct packed {
        logic [7:0] d;
        logic       irq;
        logic [2:0] off;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rd_issue = 1'b0;

    // Current scenario: LOAD edge, reload, prescale select, auto, irq enable.
    int   sc_L, sc_R, sc_P;
    logic sc_auto, sc_irqen;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Register values after edge t, from tick count n = (t-L)/2^P since the LOAD edge.
    function automatic logic [7:0] m_reg(input int off, input int t);
        int n, per, cnt;
        logic pend, ovr, run, en;
        n   = (t - sc_L) / (1 << sc_P);
        per = sc_R + 1;
        if (sc_auto) begin
            cnt = (sc_R - (n % per) + per) % per;
            pend = (n >= per); ovr = (n >= 2 * per); run = 1'b1; en = 1'b1;
        end else if (n < per) begin
            cnt = sc_R - n; pend = 1'b0; ovr = 1'b0; run = 1'b1; en = 1'b1;
        end else begin
            cnt = 0; pend = 1'b1; ovr = 1'b0; run = 1'b0; en = 1'b0;
        end
        case (off)
            0:       return {1'b0, 3'(sc_P), 1'b0, sc_irqen, sc_auto, en};
            1:       return 8'(sc_R);
            2:       return 8'(cnt);
            3:       return {5'b00000, run, ovr, pend};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic m_irq(input int t);
        logic [7:0] s;
        s = m_reg(3, t);
        return s[0] & sc_irqen;
    endfunction

    always @(posedge clk_i) begin
        if (rd_issue) begin
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected got=%h with empty scoreboard", io_data_o);
            end else begin
                mon_e = q.pop_front();
                chk($sformatf("rd_data off=%0d", mon_e.off), io_data_o, mon_e.d);
                chk($sformatf("irq off=%0d", mon_e.off), {7'b0, irq_o}, {7'b0, mon_e.irq});
            end
        end
    end

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp_d, input logic exp_i);
        io_addr_i = addr;
        rd_issue  = 1'b1;
        q.push_back('{d: exp_d, irq: exp_i, off: addr[2:0]});
        @(negedge clk_i);
        rd_issue = 1'b0;
    endtask

    task automatic rd_m(input int off);
        rd(8'(BASE + 8'(off)), m_reg(off, cyc), m_irq(cyc));
    endtask

    task automatic wr_raw(input logic [7:0] addr, input logic [7:0] d);
        io_addr_i = addr;
        io_data_i = d;
        io_we_i   = 1'b1;
        @(negedge clk_i);
        io_we_i = 1'b0;
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        wr_raw(8'(BASE + 8'(off)), d);
    endtask

    task automatic wr_at(input int edge_n, input int off, input logic [7:0] d);
        if (cyc > edge_n - 1) begin
            checks++;
            errors++;
            $display("FAIL sched edge=%0d already at cycle=%0d", edge_n, cyc);
        end
        while (cyc < edge_n - 1) @(negedge clk_i);
        wr(off, d);
    endtask

    task automatic idle_to(input int t);
        while (cyc < t) @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic start_sc(input int r, input int p, input logic a, input logic ie);
        do_reset();
        sc_R = r; sc_P = p; sc_auto = a; sc_irqen = ie;
        wr(1, 8'(r));
        wr(0, {1'b0, 3'(p), 1'b0, ie, a, 1'b1});
        sc_L = cyc + 1;
        idle_to(sc_L);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) rd(8'(BASE + 8'(i)), 8'h00, 1'b0);

        // Auto-reload, RELOAD=3, PSEL=0, IRQ enabled: walk STATUS and COUNT every cycle.
        start_sc(3, 0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) rd_m(i % 2 == 0 ? 3 : 2);

        // One-shot, RELOAD=2, PSEL=2: expiry 12 cycles after LOAD, EN self-clears.
        start_sc(2, 2, 1'b0, 1'b1);
        idle_to(sc_L + 11);
        rd_m(3); rd_m(3); rd_m(0); rd_m(2);

        // Overflow: second expiry without clear.
        start_sc(1, 0, 1'b1, 1'b0);
        idle_to(sc_L + 4);
        rd_m(3);

        // W1C on the expiry edge: set wins; later plain W1C clears and drops irq.
        start_sc(3, 0, 1'b1, 1'b1);
        wr_at(sc_L + 4, 3, 8'h01);
        rd(BASE + 8'd3, 8'h05, 1'b1);
        wr(3, 8'h01);
        rd(BASE + 8'd3, 8'h04, 1'b0);
        rd(BASE + 8'd2, 8'h00, 1'b0);
        rd(BASE + 8'd3, 8'h05, 1'b1);

        // COUNT write on a tick edge: write wins, decrement resumes next tick.
        start_sc(8'h60, 0, 1'b0, 1'b0);
        wr_at(sc_L + 5, 2, 8'h50);
        rd(BASE + 8'd2, 8'h50, 1'b0);
        rd(BASE + 8'd2, 8'h4F, 1'b0);

        // RELOAD write on the auto-reload edge: old value loaded now, new one next time.
        start_sc(3, 0, 1'b1, 1'b0);
        wr_at(sc_L + 4, 1, 8'h09);
        rd(BASE + 8'd2, 8'h03, 1'b0);
        idle_to(sc_L + 8);
        rd(BASE + 8'd2, 8'h09, 1'b0);
        rd(BASE + 8'd1, 8'h09, 1'b0);

        // Unmapped ports: writes ignored, reads zero, timer untouched.
        wr_raw(BASE + 8'd7, 8'hFF);
        wr_raw(BASE + 8'd8, 8'h00);
        rd(BASE + 8'd7, 8'h00, 1'b0);
        rd(BASE + 8'd8, 8'h00, 1'b0);
        rd(BASE + 8'd5, 8'h00, 1'b0);
        rd(BASE + 8'd6, 8'h00, 1'b0);
        rd(BASE + 8'd0, 8'h03, 1'b0);

        // Reset mid-run with irq asserted.
        start_sc(2, 0, 1'b1, 1'b1);
        idle_to(sc_L + 8);
        chk("irq_before_reset", {7'b0, irq_o}, 8'h01);
        rst_ni = 1'b0;
        #1;
        chk("irq_async_reset", {7'b0, irq_o}, 8'h00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) rd(8'(BASE + 8'(i)), 8'h00, 1'b0);

        // Randomized scenarios against the timeline model.
        for (int s = 0; s < 10; s++) begin
            start_sc(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int j = 0; j < 10; j++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk_i);
                rd_m(int'($urandom_range(0, 7)));
            end
        end

`ifdef IO_TIMER_CAPTURE_EN
        do_reset();
        wr(2, 8'h20);
        capture_i = 1'b1;
        repeat (2) @(negedge clk_i);
        capture_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rd(BASE + 8'd4, 8'h20, 1'b0);
        rd(BASE + 8'd3, 8'h08, 1'b0);
        wr(3, 8'h08);
        rd(BASE + 8'd3, 8'h00, 1'b0);
`else
        do_reset();
        wr(2, 8'h20);
        rd(BASE + 8'd4, 8'h00, 1'b0);
        rd(BASE + 8'd3, 8'h00, 1'b0);
`endif

        repeat (3) @(negedge clk_i);
        chk("scoreboard_drained", 8'(q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
